// File: rtl/cpu_div_pkg.sv
// Shared types and helpers for the iterative integer divider.
// Datapaths up to DIV_MAX_W bits wide reuse these helpers by zero-extending their operands.
package cpu_div_pkg;

  localparam int unsigned DIV_MAX_W = 64;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_ITER,
    DIV_FIX,
    DIV_DONE
  } div_state_e;

  // RISC-V divide-by-zero quotient; callers truncate it to their own width.
  localparam logic [DIV_MAX_W-1:0] DIV0_QUOTIENT = '1;

  // Two's-complement negation when the caller flags the value as negative.
  // Negation modulo 2^DIV_MAX_W truncates cleanly to any narrower width.
  function automatic logic [DIV_MAX_W-1:0] abs_if_signed(input logic [DIV_MAX_W-1:0] value,
                                                         input logic                 negate);
    return negate ? (~value + 1'b1) : value;
  endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration: shift {rem, quo} left by one,
// then subtract the divisor if the shifted remainder is large enough.
module div_step #(
  parameter int unsigned DATA_W = 64
) (
  input  logic [DATA_W-1:0] rem,
  input  logic [DATA_W-1:0] quo,
  input  logic [DATA_W-1:0] divisor_mag,
  output logic [DATA_W-1:0] next_rem,
  output logic [DATA_W-1:0] next_quo
);

  logic [DATA_W:0] shifted;
  logic [DATA_W:0] trial;

  // NOTE: combinational logic uses blocking '=' so each line sees the value
  // computed just above; every output is assigned on every path, so no latch.
  always_comb begin
    shifted  = {rem, quo[DATA_W-1]};
    // rem < divisor keeps shifted below 2*divisor, so DATA_W+1 bits give an exact sign.
    trial    = shifted - {1'b0, divisor_mag};
    next_rem = trial[DATA_W] ? shifted[DATA_W-1:0] : trial[DATA_W-1:0];
    next_quo = {quo[DATA_W-2:0], ~trial[DATA_W]};
  end

endmodule

// File: rtl/iter_divider.sv
// Multi-cycle radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU.
// Works on magnitudes, applies signs in one FIX cycle, holds results until consumed.
module iter_divider
  import cpu_div_pkg::*;
#(
  parameter int unsigned DATA_W = 64,  // 4 .. DIV_MAX_W
  parameter int unsigned CNT_W  = $clog2(DATA_W + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic              i_signed,
  input  logic [DATA_W-1:0] i_dividend,
  input  logic [DATA_W-1:0] i_divisor,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_quotient,
  output logic [DATA_W-1:0] o_remainder,
  output logic              o_div_by_zero
);

  div_state_e        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] rem_q;
  logic [DATA_W-1:0] quo_q;
  logic [DATA_W-1:0] dvs_q;
  logic              neg_quo_q;
  logic              neg_rem_q;
  logic              ready_q;
  logic              valid_q;
  logic              dbz_q;
  logic [DATA_W-1:0] quotient_q;
  logic [DATA_W-1:0] remainder_q;

  logic [DATA_W-1:0] step_rem;
  logic [DATA_W-1:0] step_quo;

  function automatic logic [DATA_W-1:0] cond_negate(input logic [DATA_W-1:0] value,
                                                    input logic              negate);
    return DATA_W'(abs_if_signed(DIV_MAX_W'(value), negate));
  endfunction

  logic dividend_neg;
  logic divisor_neg;
  logic accept;

  assign dividend_neg = i_signed & i_dividend[DATA_W-1];
  assign divisor_neg  = i_signed & i_divisor[DATA_W-1];
  assign accept       = (state_q == DIV_IDLE) & i_valid;

  div_step #(.DATA_W(DATA_W)) u_step (
    .rem        (rem_q),
    .quo        (quo_q),
    .divisor_mag(dvs_q),
    .next_rem   (step_rem),
    .next_quo   (step_quo)
  );

  // Control and output registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= DIV_IDLE;
      cnt_q       <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      ready_q     <= 1'b1;
      valid_q     <= 1'b0;
      dbz_q       <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      case (state_q)
        DIV_IDLE: begin
          if (accept) begin
            ready_q   <= 1'b0;
            cnt_q     <= CNT_W'(DATA_W);
            neg_quo_q <= dividend_neg ^ divisor_neg;
            neg_rem_q <= dividend_neg;
            if (i_divisor == '0) begin
              state_q     <= DIV_DONE;
              valid_q     <= 1'b1;
              dbz_q       <= 1'b1;
              quotient_q  <= DATA_W'(DIV0_QUOTIENT);
              remainder_q <= i_dividend;
            end else begin
              state_q <= DIV_ITER;
            end
          end
        end
        DIV_ITER: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) state_q <= DIV_FIX;
        end
        DIV_FIX: begin
          // Most-negative / -1 lands here with magnitude 2^(DATA_W-1), which is already the answer.
          quotient_q  <= cond_negate(quo_q, neg_quo_q);
          remainder_q <= cond_negate(rem_q, neg_rem_q);
          dbz_q       <= 1'b0;
          valid_q     <= 1'b1;
          state_q     <= DIV_DONE;
        end
        DIV_DONE: begin
          if (i_ready) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state_q <= DIV_IDLE;
          end
        end
        default: state_q <= DIV_IDLE;
      endcase
    end
  end

  // NOTE: the iteration datapath has no reset; it is always loaded on accept
  // before it is read, so resetting it would only add logic on the load path.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      rem_q <= '0;
      quo_q <= cond_negate(i_dividend, dividend_neg);
      dvs_q <= cond_negate(i_divisor, divisor_neg);
    end else if (state_q == DIV_ITER) begin
      rem_q <= step_rem;
      quo_q <= step_quo;
    end
  end

  assign o_ready       = ready_q;
  assign o_valid       = valid_q;
  assign o_quotient    = quotient_q;
  assign o_remainder   = remainder_q;
  assign o_div_by_zero = dbz_q;

endmodule

// File: tb/tb_iter_divider.sv
// Self-checking bench for iter_divider: directed RV64M corner cases plus
// randomized operations checked against a plain-arithmetic reference model.
module tb_iter_divider;

  localparam int W = 64;
  localparam logic [W-1:0] MIN_NEG = 64'h8000_0000_0000_0000;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         valid_in;
  logic         ready_in;
  logic         signed_in;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         ready_out;
  logic         valid_out;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         dbz;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  iter_divider #(.DATA_W(W)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_valid      (valid_in),
    .o_ready      (ready_out),
    .i_signed     (signed_in),
    .i_dividend   (dividend),
    .i_divisor    (divisor),
    .o_valid      (valid_out),
    .i_ready      (ready_in),
    .o_quotient   (quotient),
    .o_remainder  (remainder),
    .o_div_by_zero(dbz)
  );

  // RISC-V division semantics expressed with native arithmetic.
  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                                  output logic [W-1:0] q, output logic [W-1:0] r, output logic dz);
    longint sa;
    longint sb;
    dz = (b == '0);
    if (b == '0) begin
      q = '1;
      r = a;
    end else if (!sgn) begin
      q = a / b;
      r = a % b;
    end else if (a == MIN_NEG && b == '1) begin
      q = a;
      r = '0;
    end else begin
      sa = a;
      sb = b;
      q = sa / sb;
      r = sa % sb;
    end
  endfunction

  // Present one request, wait for the result; lat counts cycles from the accept edge.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                          output int lat, output logic busy_ok);
    dividend  = a;
    divisor   = b;
    signed_in = sgn;
    valid_in  = 1'b1;
    @(posedge clk); #1;
    valid_in  = 1'b0;
    dividend  = {$urandom, $urandom};
    divisor   = {$urandom, $urandom};
    signed_in = 1'($urandom);
    lat       = 1;
    busy_ok   = 1'b1;
    while (valid_out !== 1'b1 && lat < 200) begin
      if (ready_out !== 1'b0) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    if (ready_out !== 1'b0) busy_ok = 1'b0;
  endtask

  task automatic consume(output logic rel_ok);
    ready_in = 1'b1;
    @(posedge clk); #1;
    ready_in = 1'b0;
    rel_ok = (ready_out === 1'b1) && (valid_out === 1'b0);
  endtask

  task automatic test_txn(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sgn, input logic [W-1:0] eq, input logic [W-1:0] er,
                          input logic edz);
    int           lat;
    int           exp_lat;
    logic         busy_ok;
    logic         rel_ok;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    exp_lat = (b == '0) ? 1 : W + 2;
    start_op(a, b, sgn, lat, busy_ok);
    q  = quotient;
    r  = remainder;
    dz = dbz;
    consume(rel_ok);
    total++;
    if (q !== eq) begin bad++; $display("FAIL %s quotient got=%h exp=%h", nm, q, eq); end
    total++;
    if (r !== er) begin bad++; $display("FAIL %s remainder got=%h exp=%h", nm, r, er); end
    total++;
    if (dz !== edz) begin bad++; $display("FAIL %s div_by_zero got=%b exp=%b", nm, dz, edz); end
    total++;
    if (lat != exp_lat) begin bad++; $display("FAIL %s latency got=%0d exp=%0d", nm, lat, exp_lat); end
    total++;
    if (busy_ok !== 1'b1) begin bad++; $display("FAIL %s ready_while_busy got=%b exp=1", nm, busy_ok); end
    total++;
    if (rel_ok !== 1'b1) begin bad++; $display("FAIL %s release got=%b exp=1", nm, rel_ok); end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    valid_in  = 1'b0;
    ready_in  = 1'b0;
    signed_in = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({valid_out, dbz, quotient, remainder} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got valid=%b dbz=%b q=%h r=%h exp all 0", valid_out, dbz, quotient, remainder);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (ready_out !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", ready_out); end
  endtask

  task automatic test_unsigned();
    test_txn("udiv_100_7", 64'd100, 64'd7, 1'b0, 64'd14, 64'd2, 1'b0);
    test_txn("udiv_max_1", '1, 64'd1, 1'b0, '1, '0, 1'b0);
  endtask

  task automatic test_signed();
    test_txn("sdiv_m7_2", 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1,
             64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    test_txn("sdiv_7_m2", 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1,
             64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 1'b0);
    test_txn("sdiv_overflow", MIN_NEG, '1, 1'b1, MIN_NEG, '0, 1'b0);
  endtask

  task automatic test_div_by_zero();
    test_txn("dbz_signed", 64'h1234, '0, 1'b1, '1, 64'h1234, 1'b1);
    test_txn("dbz_neg", 64'hFFFF_FFFF_FFFF_FFFB, '0, 1'b1, '1, 64'hFFFF_FFFF_FFFF_FFFB, 1'b1);
  endtask

  task automatic test_backpressure();
    int           lat;
    logic         busy_ok;
    logic         rel_ok;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         stable;
    start_op(64'h1000_0001, 64'd3, 1'b0, lat, busy_ok);
    q = quotient;
    r = remainder;
    total++;
    if (q !== 64'h555_5555 || r !== 64'd2) begin
      bad++;
      $display("FAIL bp_result got q=%h r=%h exp q=5555555 r=2", q, r);
    end
    stable    = 1'b1;
    valid_in  = 1'b1;
    dividend  = 64'd50;
    divisor   = 64'd5;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (quotient !== q || remainder !== r || valid_out !== 1'b1 || ready_out !== 1'b0 || dbz !== 1'b0)
        stable = 1'b0;
    end
    valid_in = 1'b0;
    total++;
    if (stable !== 1'b1) begin bad++; $display("FAIL bp_hold got stable=%b exp=1", stable); end
    consume(rel_ok);
    total++;
    if (rel_ok !== 1'b1) begin bad++; $display("FAIL bp_release got=%b exp=1", rel_ok); end
    @(posedge clk); #1;
    total++;
    if (ready_out !== 1'b1 || valid_out !== 1'b0) begin
      bad++;
      $display("FAIL bp_no_accept got ready=%b valid=%b exp ready=1 valid=0", ready_out, valid_out);
    end
  endtask

  task automatic test_reset_mid_iter();
    logic seen;
    dividend  = 64'hDEAD;
    divisor   = 64'd7;
    signed_in = 1'b0;
    valid_in  = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    repeat (29) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    total++;
    if ({valid_out, dbz, quotient, remainder} !== '0 || ready_out !== 1'b1) begin
      bad++;
      $display("FAIL midreset_state got valid=%b dbz=%b q=%h r=%h ready=%b exp 0/0/0/0/1",
               valid_out, dbz, quotient, remainder, ready_out);
    end
    seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (valid_out !== 1'b0) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin bad++; $display("FAIL midreset_ghost got valid_seen=%b exp=0", seen); end
    test_txn("after_reset", 64'hFFFF, 64'h10, 1'b0, 64'hFFF, 64'hF, 1'b0);
  endtask

  task automatic test_random();
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sgn;
    logic [W-1:0] eq;
    logic [W-1:0] er;
    logic         edz;
    for (int i = 0; i < 40; i++) begin
      a   = {$urandom, $urandom};
      b   = {$urandom, $urandom};
      sgn = 1'($urandom);
      case ($urandom_range(0, 5))
        0: b = '0;
        1: b = 64'($urandom_range(1, 15));
        2: b = '1;
        3: a = MIN_NEG;
        4: a = 64'($urandom);
        default: ;
      endcase
      ref_div(a, b, sgn, eq, er, edz);
      test_txn($sformatf("rand_%0d", i), a, b, sgn, eq, er, edz);
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_by_zero();
    test_backpressure();
    test_reset_mid_iter();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
